prog_mem: RTL and testbench

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem.sv | 215 +++++++++++++++++++++
 tb/tb_prog_mem.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem -- loadable program memory with a registered read port.
//
// A small flop-based instruction store. Words are streamed in through a
// ready/valid load channel controlled by a three-state FSM (IDLE/LOAD/DONE).
// Reads are only served while the FSM is idle and return data one cycle
// after rd_en.
//
// Parameters
//   DATA_W  instruction word width
//   ADDR_W  address / load-length width
//   DEPTH   number of implemented words (1 .. 2**ADDR_W)
//   FILL    value returned for unwritten or unimplemented locations
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst          synchronous active-high reset; overrides every other input
//   address      read address
//   rd_en        read request (honoured in IDLE only)
//   instruction  registered read data; holds when no read is served
//   instr_valid  instruction was refreshed by last cycle's accepted read
//   ld_start     one-cycle pulse starting a load (honoured in IDLE only)
//   ld_len       number of words in the load, sampled with ld_start
//   ld_data      load word
//   ld_valid     ld_data is valid
//   ld_ready     high in LOAD; a word is taken when ld_valid & ld_ready
//   ld_done      one-cycle pulse (the DONE state) when a load completes
//   busy         high whenever the FSM is not IDLE
//   checksum     running XOR of accepted load words
//
// Build option
//   PROG_MEM_CHECKSUM_EN  when defined, checksum is a register that clears
//                         on an accepted ld_start and XORs in every accepted
//                         word (including ones beyond DEPTH). When undefined,
//                         checksum is tied to 0 and no register exists.
// -----------------------------------------------------------------------------
module prog_mem #(
  parameter int                 DATA_W = 6,
  parameter int                 ADDR_W = 8,
  parameter int                 DEPTH  = 16,
  parameter logic [DATA_W-1:0]  FILL   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd_en,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic [DATA_W-1:0] checksum
);

  // One extra bit on the pointer so DEPTH == 2**ADDR_W compares cleanly and
  // the post-increment after the final word never wraps.
  localparam int PTR_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              vld_q, vld_d;

  logic              start_acc;
  logic              accept;
  logic              last_word;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_hit;
  logic [IDX_W-1:0]  rd_idx;

  // ---------------------------------------------------------------------------
  // Load-channel handshake decode
  // ---------------------------------------------------------------------------
  assign start_acc = (state_q == IDLE) && ld_start;
  assign accept    = (state_q == LOAD) && ld_valid;
  assign last_word = accept && ((ptr_q + PTR_W'(1)) == {1'b0, len_q});

  // Words past the implemented depth are consumed but dropped.
  assign wr_en  = accept && (ptr_q < PTR_W'(DEPTH));
  assign wr_idx = ptr_q[IDX_W-1:0];

  // Reads outside the implemented depth return FILL.
  assign rd_hit = {1'b0, address} < PTR_W'(DEPTH);
  assign rd_idx = address[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, length capture and write pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          len_d   = ld_len;
          ptr_d   = '0;
          // A zero-length load has nothing to wait for.
          state_d = (ld_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + PTR_W'(1);
          if (last_word) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array. Kept in flops because reset must restore every word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL;
    end else if (wr_en) begin
      mem_q[wr_idx] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: served only while idle so a read never observes a load
  // half-way through. Data holds whenever no read is served.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_d = instr_q;
    vld_d   = 1'b0;
    if ((state_q == IDLE) && rd_en) begin
      instr_d = rd_hit ? mem_q[rd_idx] : FILL;
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= FILL;
      vld_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      vld_q   <= vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional load checksum
  // ---------------------------------------------------------------------------
`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc)   csum_d = '0;
    else if (accept) csum_d = csum_q ^ ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  // start_acc only feeds the checksum; keep it referenced so the default
  // build carries no dangling signal.
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign checksum         = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instruction = instr_q;
  assign instr_valid = vld_q;
  assign ld_ready    = (state_q == LOAD);
  assign ld_done     = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address;
  logic       rd_en;
  logic [5:0] instruction;
  logic       instr_valid;
  logic       ld_start;
  logic [7:0] ld_len;
  logic [5:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;
  logic [5:0] checksum;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of the 16 implemented words plus checksum.
  logic [5:0] m_mem [16];
  logic [5:0] m_csum;
  logic [5:0] wq [$];

  prog_mem dut (
    .clk(clk), .rst(rst), .address(address), .rd_en(rd_en),
    .instruction(instruction), .instr_valid(instr_valid),
    .ld_start(ld_start), .ld_len(ld_len), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done),
    .busy(busy), .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [5:0] m_read(input logic [7:0] a);
    return (a < 8'd16) ? m_mem[a[3:0]] : 6'h3F;
  endfunction

  function automatic logic [5:0] exp_csum();
`ifdef PROG_MEM_CHECKSUM_EN
    return m_csum;
`else
    return 6'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 6'h3F;
    m_csum = 6'h00;
  endtask

  // Issue one read in IDLE and return what appears one cycle later.
  task automatic do_rd(input logic [7:0] a, output logic [5:0] ins, output logic v);
    address = a;
    rd_en   = 1'b1;
    step();
    rd_en = 1'b0;
    ins   = instruction;
    v     = instr_valid;
  endtask

  // Drive a whole load. mode 0: valid always, 1: toggling, 2: random.
  // Returns counts of protocol observations; tests judge them.
  task automatic do_load(input int len, input int mode, input bit mid_start,
                         output int done_seen, output int proto_err, output int late);
    int accepts, cyc;
    logic v;
    accepts = 0; cyc = 0; done_seen = 0; proto_err = 0; late = 0;
    ld_start = 1'b1;
    ld_len   = len[7:0];
    step();
    ld_start = 1'b0;
    m_csum   = 6'h00;
    while (accepts < len && cyc < 400) begin
      if (ld_done) done_seen++;
      if (ld_ready !== 1'b1 || busy !== 1'b1) proto_err++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      ld_valid = v;
      ld_data  = (accepts < wq.size()) ? wq[accepts] : 6'($urandom);
      if (mid_start && cyc == 2) begin
        ld_start = 1'b1;
        ld_len   = 8'd9;
      end
      step();
      ld_start = 1'b0;
      if (v) begin
        if (accepts < 16) m_mem[accepts] = ld_data;
        m_csum ^= ld_data;
        accepts++;
      end
      cyc++;
    end
    ld_valid = 1'b0;
    if (cyc >= 400) late++;
    // Cycle right after the last accept: DONE.
    if (ld_done !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0) late++;
    if (ld_done) done_seen++;
    step();
    if (ld_done) done_seen++;
    if (busy !== 1'b0 || ld_ready !== 1'b0) proto_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1; address = '0; rd_en = 0; ld_start = 0; ld_len = '0;
    ld_data = '0; ld_valid = 0;
    step(); step();
    model_reset();
    checks++; if (instruction !== 6'h3F) begin errors++; $display("FAIL reset_instr: got %h want 3f", instruction); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", ld_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (checksum !== 6'h00) begin errors++; $display("FAIL reset_csum: got %h want 00", checksum); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill_reads();
    logic [7:0] addrs [6];
    logic [5:0] ins;
    logic v;
    addrs[0] = 8'h00; addrs[1] = 8'h0F; addrs[2] = 8'h80;
    for (int i = 3; i < 6; i++) addrs[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      do_rd(addrs[i], ins, v);
      checks++; if (ins !== 6'h3F || v !== 1'b1) begin
        errors++; $display("FAIL fill_read @%h: got %h/%b want 3f/1", addrs[i], ins, v);
      end
    end
  endtask

  task automatic test_load13();
    int dn, pe, lt;
    logic [5:0] ins;
    logic v;
    wq = '{6'h10, 6'h28, 6'h11, 6'h29, 6'h31, 6'h2A, 6'h20, 6'h29, 6'h32, 6'h28, 6'h3B, 6'h09, 6'h00};
    do_load(13, 0, 1'b0, dn, pe, lt);
    checks++; if (dn != 1 || pe != 0 || lt != 0) begin
      errors++; $display("FAIL load13_proto: done=%0d perr=%0d late=%0d want 1/0/0", dn, pe, lt);
    end
    checks++; if (checksum !== exp_csum()) begin
      errors++; $display("FAIL load13_csum: got %h want %h", checksum, exp_csum());
    end
    do_rd(8'h0A, ins, v);
    checks++; if (ins !== 6'h3B || v !== 1'b1) begin errors++; $display("FAIL load13_rd0a: got %h/%b want 3b/1", ins, v); end
    do_rd(8'h0D, ins, v);
    checks++; if (ins !== 6'h3F || v !== 1'b1) begin errors++; $display("FAIL load13_rd0d: got %h/%b want 3f/1", ins, v); end
  endtask

  task automatic test_overflow();
    int dn, pe, lt;
    logic [5:0] ins;
    logic v;
    wq.delete();
    for (int i = 1; i <= 20; i++) wq.push_back(6'(i));
    do_load(20, 0, 1'b0, dn, pe, lt);
    checks++; if (dn != 1 || pe != 0 || lt != 0) begin
      errors++; $display("FAIL ovf_proto: done=%0d perr=%0d late=%0d want 1/0/0", dn, pe, lt);
    end
    checks++; if (checksum !== exp_csum()) begin
      errors++; $display("FAIL ovf_csum: got %h want %h", checksum, exp_csum());
    end
    for (int a = 8'h0F; a <= 8'h13; a++) begin
      do_rd(8'(a), ins, v);
      checks++; if (ins !== m_read(8'(a)) || v !== 1'b1) begin
        errors++; $display("FAIL ovf_rd @%h: got %h/%b want %h/1", a, ins, v, m_read(8'(a)));
      end
    end
  endtask

  task automatic test_throttled();
    int dn, pe, lt;
    logic [5:0] ins;
    logic v;
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(6'($urandom));
    do_load(4, 1, 1'b1, dn, pe, lt);
    checks++; if (dn != 1 || pe != 0 || lt != 0) begin
      errors++; $display("FAIL thr_proto: done=%0d perr=%0d late=%0d want 1/0/0", dn, pe, lt);
    end
    for (int a = 0; a < 6; a++) begin
      do_rd(8'(a), ins, v);
      checks++; if (ins !== m_read(8'(a)) || v !== 1'b1) begin
        errors++; $display("FAIL thr_rd @%h: got %h/%b want %h/1", a, ins, v, m_read(8'(a)));
      end
    end
  endtask

  task automatic test_busy_read();
    logic [5:0] prev, d;
    prev = instruction;
    d = 6'($urandom);
    ld_start = 1'b1; ld_len = 8'd1;
    step();
    ld_start = 1'b0;
    rd_en = 1'b1; address = 8'h03; ld_valid = 1'b1; ld_data = d;
    step();                              // LOAD cycle
    ld_valid = 1'b0;
    m_mem[0] = d; m_csum = d;
    checks++; if (instr_valid !== 1'b0 || instruction !== prev) begin
      errors++; $display("FAIL busy_rd_load: got %h/%b want %h/0", instruction, instr_valid, prev);
    end
    step();                              // DONE cycle
    checks++; if (instr_valid !== 1'b0 || instruction !== prev) begin
      errors++; $display("FAIL busy_rd_done: got %h/%b want %h/0", instruction, instr_valid, prev);
    end
    step();                              // back in IDLE, read served
    checks++; if (instr_valid !== 1'b1 || instruction !== m_read(8'h03)) begin
      errors++; $display("FAIL busy_rd_idle: got %h/%b want %h/1", instruction, instr_valid, m_read(8'h03));
    end
    rd_en = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0 || instruction !== m_read(8'h03)) begin
      errors++; $display("FAIL rd_hold: got %h/%b want %h/0", instruction, instr_valid, m_read(8'h03));
    end
    do_rd(8'h00, prev, d[0]);
    checks++; if (prev !== m_read(8'h00) || d[0] !== 1'b1) begin
      errors++; $display("FAIL busy_wr0: got %h/%b want %h/1", prev, d[0], m_read(8'h00));
    end
  endtask

  task automatic test_zero_len();
    int dn, pe, lt;
    logic [5:0] ins;
    logic v;
    do_load(0, 0, 1'b0, dn, pe, lt);
    checks++; if (dn != 1 || pe != 0 || lt != 0) begin
      errors++; $display("FAIL zero_proto: done=%0d perr=%0d late=%0d want 1/0/0", dn, pe, lt);
    end
    checks++; if (checksum !== exp_csum()) begin
      errors++; $display("FAIL zero_csum: got %h want %h", checksum, exp_csum());
    end
    for (int a = 0; a < 16; a++) begin
      do_rd(8'(a), ins, v);
      checks++; if (ins !== m_read(8'(a)) || v !== 1'b1) begin
        errors++; $display("FAIL zero_rd @%h: got %h/%b want %h/1", a, ins, v, m_read(8'(a)));
      end
    end
  endtask

  task automatic test_random_loads();
    int dn, pe, lt, len;
    logic [7:0] a;
    logic [5:0] ins;
    logic v;
    for (int it = 0; it < 5; it++) begin
      wq.delete();
      len = $urandom_range(0, 22);
      do_load(len, 2, 1'($urandom), dn, pe, lt);
      checks++; if (dn != 1 || pe != 0 || lt != 0) begin
        errors++; $display("FAIL rnd_proto len=%0d: done=%0d perr=%0d late=%0d want 1/0/0", len, dn, pe, lt);
      end
      checks++; if (checksum !== exp_csum()) begin
        errors++; $display("FAIL rnd_csum: got %h want %h", checksum, exp_csum());
      end
      for (int r = 0; r < 6; r++) begin
        a = (r < 4) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        do_rd(a, ins, v);
        checks++; if (ins !== m_read(a) || v !== 1'b1) begin
          errors++; $display("FAIL rnd_rd @%h: got %h/%b want %h/1", a, ins, v, m_read(a));
        end
      end
    end
  endtask

  task automatic test_abort();
    int dn;
    logic [5:0] ins;
    logic v;
    dn = 0;
    ld_start = 1'b1; ld_len = 8'd5;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ld_data = 6'($urandom);
      step();
      if (ld_done) dn++;
    end
    rst = 1'b1;                          // ld_valid still high: reset wins
    ld_start = 1'b1; ld_len = 8'd3;
    step();
    if (ld_done) dn++;
    rst = 1'b0; ld_valid = 1'b0; ld_start = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      if (ld_done) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_done: pulses %0d want 0", dn); end
    checks++; if (busy !== 1'b0 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b ready=%b want 0/0", busy, ld_ready);
    end
    checks++; if (checksum !== 6'h00) begin errors++; $display("FAIL abort_csum: got %h want 00", checksum); end
    for (int a = 0; a < 17; a++) begin
      do_rd(8'(a), ins, v);
      checks++; if (ins !== 6'h3F || v !== 1'b1) begin
        errors++; $display("FAIL abort_rd @%h: got %h/%b want 3f/1", a, ins, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_reads();
    test_load13();
    test_overflow();
    test_throttled();
    test_busy_read();
    test_zero_len();
    test_random_loads();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
